// File: rtl/alu_exec_stage.sv
// Execute stage around a 16-bit 74181-style ALU: registers the operation, captures result, tag and Z/N/C flags.
// Latency: operation accepted at one edge, ALU settles for one cycle, result is valid after the following edge.
// Backpressure: DONE holds the result until out_ready; in_ready follows out_ready there, and flush blocks accepts.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic             in_m,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_setf,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       alu_s_q;
  logic             alu_m_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [TAG_W-1:0] tag_q;
  logic             setf_q;
  logic [WIDTH-1:0] out_y_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             z_q, n_q, c_q;
  logic             accept;
  logic             capture;

  // Next-state and upstream ready; flush wins over every other action and blocks accepts.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) state_d = ST_EXEC;
        end
        ST_EXEC: state_d = ST_DONE;
        ST_DONE: begin
          in_ready = out_ready;
          if (out_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign accept  = in_valid & in_ready;
  // Result is taken at the end of EXEC unless that cycle is flushed.
  assign capture = (state_q == ST_EXEC) & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operation registers load only on accept so the ALU inputs stay stable between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_s_q <= 4'd0;
      alu_m_q <= 1'b1;
      alu_a_q <= '0;
      alu_b_q <= '0;
      tag_q   <= '0;
      setf_q  <= 1'b0;
    end else if (accept) begin
      alu_s_q <= in_s;
      alu_m_q <= in_m;
      alu_a_q <= in_a;
      alu_b_q <= in_b;
      tag_q   <= in_tag;
      setf_q  <= in_setf;
    end
  end

  // Result and tag capture; held through DONE stalls and flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_y_q   <= '0;
      out_tag_q <= '0;
    end else if (capture) begin
      out_y_q   <= alu_y;
      out_tag_q <= tag_q;
    end
  end

  // Flags update only from a captured operation that asked for it; carry is meaningless in logic mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else if (capture && setf_q) begin
      z_q <= (alu_y == '0);
      n_q <= alu_y[WIDTH-1];
      c_q <= alu_m_q ? 1'b0 : alu_co;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_m     = alu_m_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = (state_q == ST_DONE);
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU stub on the alu_* side, arithmetic reference model for results and flags.
// Inputs are driven 1ns after the rising edge and outputs sampled at the same point, away from the edge.
// Scenarios: reset, single arithmetic op, logic ops with setf=0, backpressure, back-to-back stream, flush, reset in DONE, random.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_s;
  logic        in_m;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_tag;
  logic        in_setf;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_co;
  logic        out_valid, out_ready;
  logic [15:0] out_y;
  logic [2:0]  out_tag;
  logic        flag_z, flag_n, flag_c, busy;

  int checks   = 0;
  int failures = 0;
  logic ez = 1'b0, en = 1'b0, ec = 1'b0;

  alu_exec_stage #(.WIDTH(16), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_m(in_m), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_setf(in_setf),
    .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_co(alu_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: sum with carry in arithmetic mode, bitwise AND in logic mode.
  always_comb begin
    if (alu_m) {alu_co, alu_y} = {1'b0, alu_a & alu_b};
    else       {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: expected result and, when setf, the new flags (integer arithmetic).
  task automatic model_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                          input logic setf, output logic [15:0] ey);
    int unsigned r;
    if (m) r = 32'(a & b);
    else   r = 32'(a) + 32'(b);
    ey = 16'(r % 65536);
    if (setf) begin
      ez = (r % 65536 == 0);
      en = (r % 65536 >= 32768);
      ec = !m && (r >= 65536);
    end
  endtask

  // Presents one op from IDLE; returns edges counted from presentation until out_valid (capped).
  task automatic run_op(input logic [3:0] s, input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tag, input logic setf, output int lat);
    in_s = s; in_m = m; in_a = a; in_b = b; in_tag = tag; in_setf = setf; in_valid = 1'b1;
    tick;
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_s = 4'd0; in_m = 1'b0; in_a = 16'd0; in_b = 16'd0; in_tag = 3'd0; in_setf = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({out_valid, out_y, out_tag, busy} !== 21'd0) begin
      failures++;
      $display("FAIL reset_out: valid=%b y=%h tag=%0d busy=%b want all 0", out_valid, out_y, out_tag, busy);
    end
    checks++;
    if ({alu_s, alu_m, alu_a, alu_b} !== {4'd0, 1'b1, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL reset_alu: s=%h m=%b a=%h b=%h want s=0 m=1 a=0 b=0", alu_s, alu_m, alu_a, alu_b);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({flag_z, flag_n, flag_c, busy} !== 4'b0000) begin
        failures++;
        $display("FAIL idle_flags cycle %0d: znc=%b%b%b busy=%b want 0000", i, flag_z, flag_n, flag_c, busy);
      end
    end
  endtask

  task automatic test_single;
    logic [15:0] ey;
    int lat;
    model_op(1'b0, 16'h8000, 16'h8000, 1'b1, ey);
    run_op(4'h9, 1'b0, 16'h8000, 16'h8000, 3'd5, 1'b1, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL single_latency: %0d edges want 2", lat);
    end
    checks++;
    if ({out_y, out_tag} !== {16'h0000, 3'd5}) begin
      failures++;
      $display("FAIL single_result: y=%h tag=%0d want y=0000 tag=5", out_y, out_tag);
    end
    checks++;
    if ({flag_z, flag_n, flag_c} !== 3'b101) begin
      failures++;
      $display("FAIL single_flags: znc=%b%b%b want 101", flag_z, flag_n, flag_c);
    end
    tick;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL single_idle: valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_logic;
    logic [15:0] ey;
    int lat;
    model_op(1'b1, 16'hF0F0, 16'hFF00, 1'b1, ey);
    run_op(4'hB, 1'b1, 16'hF0F0, 16'hFF00, 3'd2, 1'b1, lat);
    checks++;
    if ({out_y, flag_z, flag_n, flag_c} !== {16'hF000, 3'b010}) begin
      failures++;
      $display("FAIL logic_op: y=%h znc=%b%b%b want y=f000 znc=010", out_y, flag_z, flag_n, flag_c);
    end
    tick;
    model_op(1'b1, 16'h0000, 16'h0000, 1'b0, ey);
    run_op(4'hB, 1'b1, 16'h0000, 16'h0000, 3'd3, 1'b0, lat);
    checks++;
    if ({out_y, out_tag, flag_z, flag_n, flag_c} !== {16'h0000, 3'd3, 3'b010}) begin
      failures++;
      $display("FAIL logic_nosetf: y=%h tag=%0d znc=%b%b%b want y=0000 tag=3 znc=010",
               out_y, out_tag, flag_z, flag_n, flag_c);
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [15:0] a0, b0, a1, b1, ey0, ey1;
    logic m0, m1;
    int lat;
    a0 = 16'($urandom); b0 = 16'($urandom); m0 = 1'($urandom);
    a1 = 16'($urandom); b1 = 16'($urandom); m1 = 1'($urandom);
    out_ready = 1'b0;
    model_op(m0, a0, b0, 1'b1, ey0);
    run_op(4'h6, m0, a0, b0, 3'd4, 1'b1, lat);
    checks++;
    if (lat !== 2 || out_y !== ey0) begin
      failures++;
      $display("FAIL bp_first: lat=%0d y=%h want lat=2 y=%h", lat, out_y, ey0);
    end
    // Second op offered during the stall must be ignored.
    in_s = 4'h3; in_m = m1; in_a = a1; in_b = b1; in_tag = 3'd6; in_setf = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({out_valid, in_ready, out_y, out_tag} !== {1'b1, 1'b0, ey0, 3'd4}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b y=%h tag=%0d want 1 0 %h 4",
                 i, out_valid, in_ready, out_y, out_tag, ey0);
      end
      checks++;
      if ({alu_s, alu_m, alu_a, alu_b, flag_z, flag_n, flag_c} !== {4'h6, m0, a0, b0, ez, en, ec}) begin
        failures++;
        $display("FAIL bp_alu cycle %0d: s=%h m=%b a=%h b=%h znc=%b%b%b want 6 %b %h %h %b%b%b",
                 i, alu_s, alu_m, alu_a, alu_b, flag_z, flag_n, flag_c, m0, a0, b0, ez, en, ec);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, busy, alu_a, alu_b} !== {1'b0, 1'b1, a1, b1}) begin
      failures++;
      $display("FAIL bp_reexec: valid=%b busy=%b a=%h b=%h want 0 1 %h %h", out_valid, busy, alu_a, alu_b, a1, b1);
    end
    tick;
    model_op(m1, a1, b1, 1'b1, ey1);
    checks++;
    if ({out_valid, out_y, out_tag, flag_z, flag_n, flag_c} !== {1'b1, ey1, 3'd6, ez, en, ec}) begin
      failures++;
      $display("FAIL bp_second: valid=%b y=%h tag=%0d znc=%b%b%b want 1 %h 6 %b%b%b",
               out_valid, out_y, out_tag, flag_z, flag_n, flag_c, ey1, ez, en, ec);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] qa[8], qb[8];
    logic        qm[8], qf[8];
    logic [15:0] ey;
    logic        acc;
    int idx = 0, got = 0, last = 0;
    for (int i = 0; i < 8; i++) begin
      qa[i] = 16'($urandom); qb[i] = 16'($urandom); qm[i] = 1'($urandom); qf[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_s = 4'(idx); in_m = qm[idx]; in_a = qa[idx]; in_b = qb[idx]; in_tag = 3'(idx); in_setf = qf[idx];
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        model_op(qm[got], qa[got], qb[got], qf[got], ey);
        checks++;
        if ({out_y, out_tag, flag_z, flag_n, flag_c} !== {ey, 3'(got), ez, en, ec}) begin
          failures++;
          $display("FAIL b2b_result %0d: y=%h tag=%0d znc=%b%b%b want %h %0d %b%b%b",
                   got, out_y, out_tag, flag_z, flag_n, flag_c, ey, got, ez, en, ec);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last !== 2) begin
            failures++;
            $display("FAIL b2b_spacing %0d: %0d cycles want 2", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 8) begin
      failures++;
      $display("FAIL b2b_count: %0d results want 8", got);
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL b2b_drain cycle %0d: valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
      tick;
    end
  endtask

  task automatic test_flush;
    int lat;
    in_s = 4'h1; in_m = 1'b0; in_a = 16'h0001; in_b = 16'h0001; in_tag = 3'd1; in_setf = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL flush_exec: busy=%b ready=%b want 1 0", busy, in_ready);
    end
    tick;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, busy, flag_z, flag_n, flag_c} !== {2'b00, ez, en, ec}) begin
        failures++;
        $display("FAIL flush_discard cycle %0d: valid=%b busy=%b znc=%b%b%b want 0 0 %b%b%b",
                 i, out_valid, busy, flag_z, flag_n, flag_c, ez, en, ec);
      end
      tick;
    end
    // Flush in IDLE blocks an offered op.
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_ready: in_ready=%b want 0", in_ready);
    end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_accept: busy=%b want 0", busy);
    end
    // Reset while a result is held.
    out_ready = 1'b0;
    run_op(4'hE, 1'b0, 16'hFFFF, 16'h0002, 3'd7, 1'b1, lat);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ez = 1'b0; en = 1'b0; ec = 1'b0;
    checks++;
    if ({out_valid, out_y, out_tag, busy, flag_z, flag_n, flag_c} !== 24'd0 ||
        {alu_s, alu_m, alu_a, alu_b} !== {4'd0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL rst_in_done: valid=%b y=%h tag=%0d busy=%b znc=%b%b%b s=%h m=%b a=%h b=%h want reset values",
               out_valid, out_y, out_tag, busy, flag_z, flag_n, flag_c, alu_s, alu_m, alu_a, alu_b);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random;
    logic [15:0] a, b, ey;
    logic [3:0]  s;
    logic        m, f;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); f = 1'($urandom);
      if (i % 4 == 0) b = 16'(0 - a);
      model_op(m, a, b, f, ey);
      run_op(s, m, a, b, 3'(i), f, lat);
      checks++;
      if (lat !== 2 || {out_y, out_tag, alu_s} !== {ey, 3'(i), s}) begin
        failures++;
        $display("FAIL rand_result %0d: lat=%0d y=%h tag=%0d s=%h want 2 %h %0d %h", i, lat, out_y, out_tag, alu_s, ey, i, s);
      end
      checks++;
      if ({flag_z, flag_n, flag_c} !== {ez, en, ec}) begin
        failures++;
        $display("FAIL rand_flags %0d: znc=%b%b%b want %b%b%b", i, flag_z, flag_n, flag_c, ez, en, ec);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_logic;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
